// File: rtl/mode_controller.sv
// mode_controller: turns the four front-panel buttons into pulses routed to the
// time setter, the alarm setter or the stopwatch. It also supervises edits with commit and timeout.
module mode_controller #(
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       set_btn,
    input  logic       up_btn,
    input  logic       down_btn,
    input  logic       time_busy,
    input  logic       alarm_busy,
    input  logic       time_propagate,
    input  logic       alarm_propagate,
    output logic       time_set,
    output logic       time_up,
    output logic       time_down,
    output logic       alarm_set,
    output logic       alarm_up,
    output logic       alarm_down,
    output logic       time_abort,
    output logic       alarm_abort,
    output logic       load_time,
    output logic       load_alarm,
    output logic       sw_run,
    output logic       sw_clear,
    output logic [1:0] mode,
    output logic       locked
);
    logic [3:0] btn_q, pulse;
    logic p_mode, p_set, p_up, p_down;
    logic lock_now, adv, do_set, do_up, do_down, any_key;
    logic commit_t, commit_a, expire, run_n, lock_n;
    logic [1:0] mode_n;
    logic [15:0] idle;

    assign pulse = {mode_btn, set_btn, up_btn, down_btn} & ~btn_q;
    assign {p_mode, p_set, p_up, p_down} = pulse;

    // Mode decisions use the live busy inputs; the locked output is their registered view.
    always_comb begin
        lock_now = (mode == 2'd1 & time_busy) | (mode == 2'd2 & alarm_busy) | (mode == 2'd3 & sw_run);
        adv      = p_mode & ~lock_now;
        do_set   = ~adv & p_set;
        do_up    = ~adv & ~p_set & p_up;
        do_down  = ~adv & ~p_set & ~p_up & p_down;
        any_key  = do_set | do_up | do_down;
        commit_t = (mode == 2'd1) & time_propagate;
        commit_a = (mode == 2'd2) & alarm_propagate;
        expire   = lock_now & (mode == 2'd1 | mode == 2'd2) & ~any_key & ~commit_t & ~commit_a
                   & (idle == 16'(TIMEOUT - 1));
        mode_n   = (commit_t | commit_a | expire) ? 2'd0 : adv ? mode + 2'd1 : mode;
        run_n    = (mode == 2'd3 & do_set) ? ~sw_run : sw_run;
        lock_n   = (mode_n == 2'd1 & time_busy) | (mode_n == 2'd2 & alarm_busy) | (mode_n == 2'd3 & run_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q       <= 4'hF;
            mode        <= 2'd0;
            sw_run      <= 1'b0;
            locked      <= 1'b0;
            idle        <= 16'd0;
            time_set    <= 1'b0;
            time_up     <= 1'b0;
            time_down   <= 1'b0;
            alarm_set   <= 1'b0;
            alarm_up    <= 1'b0;
            alarm_down  <= 1'b0;
            time_abort  <= 1'b0;
            alarm_abort <= 1'b0;
            load_time   <= 1'b0;
            load_alarm  <= 1'b0;
            sw_clear    <= 1'b0;
        end else begin
            btn_q       <= {mode_btn, set_btn, up_btn, down_btn};
            mode        <= mode_n;
            sw_run      <= run_n;
            locked      <= lock_n;
            idle        <= (~lock_now | mode == 2'd3 | any_key | commit_t | commit_a | expire) ? 16'd0 : idle + 16'd1;
            time_set    <= mode == 2'd1 & do_set;
            time_up     <= mode == 2'd1 & do_up;
            time_down   <= mode == 2'd1 & do_down;
            alarm_set   <= mode == 2'd2 & do_set;
            alarm_up    <= mode == 2'd2 & do_up;
            alarm_down  <= mode == 2'd2 & do_down;
            time_abort  <= expire & mode == 2'd1;
            alarm_abort <= expire & mode == 2'd2;
            load_time   <= commit_t;
            load_alarm  <= commit_a;
            sw_clear    <= mode == 2'd3 & do_up & ~sw_run;
        end
    end
endmodule

// File: tb/tb_mode_controller.sv
// tb_mode_controller: directed scenarios plus randomized traffic checked every cycle
// against a behavioural model of the front-panel rules.
module tb_mode_controller;
    localparam int TO = 8;

    logic clk = 0, reset = 1;
    logic mode_btn = 0, set_btn = 0, up_btn = 0, down_btn = 0;
    logic time_busy = 0, alarm_busy = 0, time_propagate = 0, alarm_propagate = 0;
    logic time_set, time_up, time_down, alarm_set, alarm_up, alarm_down;
    logic time_abort, alarm_abort, load_time, load_alarm, sw_run, sw_clear, locked;
    logic [1:0] mode;

    int checks = 0, failures = 0;

    int m_mode = 0, m_quiet = 0;
    bit m_run = 0, m_locked = 0;
    bit m_pb[4] = '{1, 1, 1, 1};
    bit e_ts, e_tu, e_td, e_as, e_au, e_ad, e_ta, e_aa, e_lt, e_la, e_clr;

    mode_controller #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .mode_btn(mode_btn), .set_btn(set_btn), .up_btn(up_btn), .down_btn(down_btn),
        .time_busy(time_busy), .alarm_busy(alarm_busy),
        .time_propagate(time_propagate), .alarm_propagate(alarm_propagate),
        .time_set(time_set), .time_up(time_up), .time_down(time_down),
        .alarm_set(alarm_set), .alarm_up(alarm_up), .alarm_down(alarm_down),
        .time_abort(time_abort), .alarm_abort(alarm_abort),
        .load_time(load_time), .load_alarm(load_alarm),
        .sw_run(sw_run), .sw_clear(sw_clear), .mode(mode), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: evaluates the panel rules once per rising edge from the applied inputs.
    task automatic model();
        bit pm, ps, pu, pd, lk, advance, commit;
        int key, nmode;
        bit nrun;
        {e_ts, e_tu, e_td, e_as, e_au, e_ad, e_ta, e_aa, e_lt, e_la, e_clr} = '0;
        if (reset) begin
            m_mode = 0; m_run = 0; m_locked = 0; m_quiet = 0;
            m_pb = '{1, 1, 1, 1};
            return;
        end
        pm = mode_btn && !m_pb[0];
        ps = set_btn && !m_pb[1];
        pu = up_btn && !m_pb[2];
        pd = down_btn && !m_pb[3];
        lk = (m_mode == 1 && time_busy) || (m_mode == 2 && alarm_busy) || (m_mode == 3 && m_run);
        advance = pm && !lk;
        key = advance ? 0 : ps ? 1 : pu ? 2 : pd ? 3 : 0;
        nrun = m_run;
        if (m_mode == 1) begin
            e_ts = key == 1; e_tu = key == 2; e_td = key == 3;
        end else if (m_mode == 2) begin
            e_as = key == 1; e_au = key == 2; e_ad = key == 3;
        end else if (m_mode == 3) begin
            if (key == 1) nrun = !m_run;
            e_clr = key == 2 && !m_run;
        end
        commit = (m_mode == 1 && time_propagate) || (m_mode == 2 && alarm_propagate);
        nmode = advance ? (m_mode + 1) % 4 : m_mode;
        if ((m_mode == 1 || m_mode == 2) && lk && key == 0 && !commit) begin
            m_quiet++;
            if (m_quiet == TO) begin
                if (m_mode == 1) e_ta = 1; else e_aa = 1;
                nmode = 0;
                m_quiet = 0;
            end
        end else m_quiet = 0;
        if (commit) begin
            if (m_mode == 1) e_lt = 1; else e_la = 1;
            nmode = 0;
        end
        m_mode = nmode;
        m_run = nrun;
        m_locked = (nmode == 1 && time_busy) || (nmode == 2 && alarm_busy) || (nmode == 3 && nrun);
        m_pb = '{mode_btn, set_btn, up_btn, down_btn};
    endtask

    task automatic compare();
        check("mode", mode, m_mode);
        check("locked", locked, m_locked);
        check("sw_run", sw_run, m_run);
        check("sw_clear", sw_clear, e_clr);
        check("time_set", time_set, e_ts);
        check("time_up", time_up, e_tu);
        check("time_down", time_down, e_td);
        check("alarm_set", alarm_set, e_as);
        check("alarm_up", alarm_up, e_au);
        check("alarm_down", alarm_down, e_ad);
        check("time_abort", time_abort, e_ta);
        check("alarm_abort", alarm_abort, e_aa);
        check("load_time", load_time, e_lt);
        check("load_alarm", load_alarm, e_la);
    endtask

    task automatic tick();
        @(posedge clk);
        model();
        #1;
        compare();
    endtask

    task automatic press_mode();
        mode_btn = 1; tick();
        mode_btn = 0; tick();
    endtask

    initial begin
        int rate;
        // Set held through reset must not produce a pulse.
        set_btn = 1;
        tick(); tick();
        check("rst_mode", mode, 0);
        check("rst_locked", locked, 0);
        reset = 0;
        tick();
        mode_btn = 1; tick();
        check("dir_mode1", mode, 1);
        mode_btn = 0; tick(); tick();
        check("dir_held_set", time_set, 0);
        set_btn = 0; tick();
        set_btn = 1; tick();
        check("dir_set_pulse", time_set, 1);
        check("dir_alarm_quiet", alarm_set, 0);
        set_btn = 0; tick();
        check("dir_set_one_cycle", time_set, 0);
        press_mode();
        check("dir_mode2", mode, 2);
        press_mode();
        check("dir_mode3", mode, 3);
        press_mode(); press_mode();
        // Locked edit in mode 1, then commit.
        time_busy = 1; tick();
        check("dir_locked", locked, 1);
        press_mode();
        check("dir_lock_hold", mode, 1);
        time_propagate = 1; tick();
        check("dir_load_time", load_time, 1);
        check("dir_commit_mode", mode, 0);
        time_propagate = 0; time_busy = 0; tick();
        check("dir_load_once", load_time, 0);
        // Stopwatch.
        press_mode(); press_mode(); press_mode();
        set_btn = 1; tick();
        check("dir_sw_run", sw_run, 1);
        check("dir_sw_locked", locked, 1);
        set_btn = 0; tick();
        up_btn = 1; tick();
        check("dir_no_clear", sw_clear, 0);
        up_btn = 0; tick();
        press_mode();
        check("dir_sw_mode_hold", mode, 3);
        set_btn = 1; tick(); set_btn = 0; tick();
        check("dir_sw_stop", sw_run, 0);
        up_btn = 1; tick();
        check("dir_clear", sw_clear, 1);
        up_btn = 0; tick();
        // Timeout in mode 2 with a restarting press at cycle 5.
        press_mode(); press_mode(); press_mode();
        alarm_busy = 1;
        up_btn = 1; tick();
        check("dir_alarm_up", alarm_up, 1);
        up_btn = 0;
        for (int i = 0; i < 4; i++) tick();
        down_btn = 1; tick();
        down_btn = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("dir_no_abort_early", alarm_abort, 0);
        end
        tick();
        check("dir_alarm_abort", alarm_abort, 1);
        check("dir_abort_mode", mode, 0);
        alarm_busy = 0; tick();
        // Same-cycle combinations.
        press_mode();
        mode_btn = 1; up_btn = 1; tick();
        check("dir_combo_mode", mode, 2);
        check("dir_combo_no_up", time_up, 0);
        mode_btn = 0; up_btn = 0; tick();
        set_btn = 1; down_btn = 1; tick();
        check("dir_prio_set", alarm_set, 1);
        check("dir_prio_down", alarm_down, 0);
        set_btn = 0; down_btn = 0; tick();
        // Randomized traffic.
        rate = 4;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) rate = $urandom_range(2, 12);
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, rate - 1) == 0) mode_btn = ~mode_btn;
            if ($urandom_range(0, rate - 1) == 0) set_btn = ~set_btn;
            if ($urandom_range(0, rate - 1) == 0) up_btn = ~up_btn;
            if ($urandom_range(0, rate - 1) == 0) down_btn = ~down_btn;
            if ($urandom_range(0, 15) == 0) time_busy = ~time_busy;
            if ($urandom_range(0, 15) == 0) alarm_busy = ~alarm_busy;
            time_propagate = ($urandom_range(0, 29) == 0);
            alarm_propagate = ($urandom_range(0, 29) == 0);
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mode_controller.md
# mode_controller

Front-panel controller for the 24-hour clock. It turns the four push buttons (mode, set, up, down) into single-cycle pulses and routes them to exactly one settable sub-block at a time: the time setter, the alarm setter or the stopwatch. Mode changes are locked while a setter is mid-edit or the stopwatch is running. When a setter propagates, the controller issues the matching load strobe, and it aborts an edit abandoned for too long.

## Interface
- TIMEOUT, 1000: idle clock cycles allowed during a locked edit before abort; legal range 2..65535.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mode_btn, set_btn, up_btn, down_btn  in  1 each  raw button levels, synchronous to clk.
- time_busy, alarm_busy  in  1 each  setter is mid-edit (its currentState != 0).
- time_propagate, alarm_propagate  in  1 each  setter finished an edit.
- time_set, time_up, time_down  out  1 each  pulses to the time setter.
- alarm_set, alarm_up, alarm_down  out  1 each  pulses to the alarm setter.
- time_abort, alarm_abort  out  1 each  forces the setter back to its idle state.
- load_time, load_alarm  out  1 each  commit strobes to the time/alarm registers.
- sw_run  out  1  stopwatch run level.
- sw_clear  out  1  stopwatch clear pulse.
- mode  out  2  0 = display, 1 = time set, 2 = alarm set, 3 = stopwatch.
- locked  out  1  mode changes are blocked.

## Operation
- Edge detect: pulse = btn & ~btn_q, with btn_q registered every cycle. Reset loads btn_q = 1, so a button held through reset produces no pulse until it is released and pressed again.
- Mode selection: an unlocked mode press advances mode 0→1→2→3→0. A locked mode press is dropped.
- locked = (mode==1 & time_busy) | (mode==2 & alarm_busy) | (mode==3 & sw_run).
- Routing (at most one pulse forwarded per cycle; priority set > up > down, lower-priority presses in that cycle are dropped):
  - mode 0: set/up/down ignored.
  - mode 1: presses go to time_* outputs.
  - mode 2: presses go to alarm_* outputs.
  - mode 3: set toggles sw_run; up pulses sw_clear only when sw_run = 0; down is ignored.
- Mode press together with set/up/down in the same cycle:
  - unlocked: mode advances and the other presses are dropped.
  - locked: mode press dropped, the other press is routed normally.
- Commit: time_propagate sampled high while mode==1 → load_time pulse and mode←0 on the same edge. alarm_propagate with mode==2 behaves the same way via load_alarm. A propagate input seen in any other mode is ignored.
- Timeout:
  - 16-bit idle counter cleared on any accepted set/up/down pulse, and whenever locked = 0 or mode == 3.
  - Otherwise it increments each cycle.
  - On reaching TIMEOUT-1: abort pulse to the active setter (time_abort in mode 1, alarm_abort in mode 2), mode←0, counter←0.
- Propagate and timeout in the same cycle: propagate wins, no abort.

## Timing
- All outputs are registered.
- Reset values: mode 0, locked 0, sw_run 0, every pulse output 0.
- Button latency: raw rise sampled at edge k → routed pulse high from edge k to edge k+1, exactly one cycle.
- Commit latency: propagate sampled at edge k → load_* high for one cycle after edge k; mode reads 0 after edge k.
- locked follows its inputs with one cycle of latency. Busy inputs are sampled at edge k, and locked is valid after edge k.
- Abort: asserted for one cycle, TIMEOUT cycles after the last accepted press.
- Reset mid-operation overrides everything on that edge: no pulse is emitted, and sw_run clears.

## Test plan
- Reset with set_btn held high → no pulse after reset release. Release, then press again → exactly one set pulse, routed by mode.
- Press mode three times (unlocked) → mode reads 1, 2, 3. In mode 1, set press → time_set high one cycle; alarm_* stay 0.
- Mode 1, time_busy = 1, mode press → mode stays 1. Drive time_propagate for one cycle → load_time pulse one cycle later and mode = 0.
- Mode 3: set → sw_run = 1 and locked = 1; up → no sw_clear; mode press ignored. Set again → sw_run = 0; up → sw_clear pulse.
- TIMEOUT = 8, mode 2, alarm_busy = 1, no presses → alarm_abort pulses 8 cycles after the last press and mode becomes 0. A press at cycle 5 restarts the count.
- Same cycle mode + up while unlocked in mode 1 → mode becomes 2 and no time_up pulse. Set + down in the same cycle → only the set pulse is forwarded.
